// File: rtl/instruction_fetch.sv
// PC generation and IF/ID staging register in front of a combinational-read instruction memory.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] read_address,
    input  logic [31:0] instruction_code,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_range;
    logic        halted;
    logic        trap;

    assign read_address = pc;
    assign pc_plus4     = pc + 32'd4;
    assign in_range     = (pc <= LAST_PC);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state;

    assign halted = (state == HALT);
    assign trap   = redirect_valid && (redirect_target[1:0] != 2'b00);

    // Once halted, only reset clears the fault; stall and redirect are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            fetch_fault <= 1'b0;
        end else if (!halted && trap) begin
            state       <= HALT;
            fetch_fault <= 1'b1;
        end
    end
`else
    logic unused_target_lsbs;

    assign halted             = 1'b0;
    assign trap               = 1'b0;
    assign fetch_fault        = 1'b0;
    assign unused_target_lsbs = ^redirect_target[1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                <= RESET_PC;
            if_id_pc          <= '0;
            if_id_pc_plus4    <= '0;
            if_id_instruction <= NOP;
            if_id_valid       <= 1'b0;
            fetch_count       <= '0;
        end else if (halted || trap) begin
            if_id_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= {redirect_target[31:2], 2'b00};
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if (!in_range) begin
                // Parked past the end of memory until a redirect arrives.
                if_id_valid <= 1'b0;
            end else begin
                pc                <= pc_plus4;
                if_id_pc          <= pc;
                if_id_pc_plus4    <= pc_plus4;
                if_id_instruction <= instruction_code;
                if_id_valid       <= 1'b1;
                fetch_count       <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes reference-model predictions,
// a monitor pops and compares after every rising edge.
module tb_instruction_fetch;

    localparam int unsigned IMEM_BYTES = 1024;
    localparam int unsigned WORDS      = IMEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] read_address;
    logic [31:0] instruction_code;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        fetch_fault;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .read_address      (read_address),
        .instruction_code  (instruction_code),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .fetch_count       (fetch_count),
        .fetch_fault       (fetch_fault)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [WORDS];
    assign instruction_code = (read_address < 32'(IMEM_BYTES)) ? mem[read_address[9:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ip4;
        logic [31:0] instr;
        logic [31:0] count;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   pushes = 0;
    int   pops   = 0;

    // Reference model state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc, m_ipc, m_ip4, m_instr, m_count;
    logic        m_valid, m_fault, m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0; m_instr = 32'h13;
        m_count = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
    endtask

    // Called at a falling edge: drive, predict the next edge, push, advance to next falling edge.
    task automatic step(input logic s, input logic rv, input logic [31:0] tgt);
        exp_t e;
        stall = s; redirect_valid = rv; redirect_target = tgt;
        if (m_halt) begin
            m_valid = 1'b0;
        end else if (rv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) begin
                m_halt = 1'b1; m_fault = 1'b1; m_valid = 1'b0;
            end else begin
                m_pc = tgt; m_valid = 1'b0;
            end
`else
            m_pc = tgt - (tgt % 4); m_valid = 1'b0;
`endif
        end else if (s) begin
            // everything holds
        end else if (m_pc > 32'(IMEM_BYTES - 4)) begin
            m_valid = 1'b0;
        end else begin
            m_ipc = m_pc; m_ip4 = m_pc + 4; m_instr = mem[m_pc / 4];
            m_valid = 1'b1; m_count = m_count + 1; m_pc = m_pc + 4;
        end
        e.pc = m_pc; e.ipc = m_ipc; e.ip4 = m_ip4; e.instr = m_instr;
        e.count = m_count; e.valid = m_valid; e.fault = m_fault;
        q.push_back(e);
        pushes++;
        @(negedge clk);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            pops++;
            chk("read_address", read_address, e.pc);
            chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
            chk("if_id_pc", if_id_pc, e.ipc);
            chk("if_id_pc_plus4", if_id_pc_plus4, e.ip4);
            chk("if_id_instruction", if_id_instruction, e.instr);
            chk("fetch_count", fetch_count, e.count);
            chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_read_address"}, read_address, 32'h0);
        chk({tag, "_if_id_pc"}, if_id_pc, 32'h0);
        chk({tag, "_if_id_pc_plus4"}, if_id_pc_plus4, 32'h0);
        chk({tag, "_if_id_instruction"}, if_id_instruction, 32'h0000_0013);
        chk({tag, "_if_id_valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, "_fetch_count"}, fetch_count, 32'h0);
        chk({tag, "_fetch_fault"}, 32'(fetch_fault), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom();
        mem[0] = 32'h003100B3;
        mem[1] = 32'h403100B3;
        mem[5] = 32'h02A10093;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        model_reset();
        #2;
        chk_reset_values("por");
        @(negedge clk);
        reset = 1'b0;

        // Two sequential fetches, then a three-cycle stall at pc=8.
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        // Redirect wins over a simultaneous stall; one bubble then target fetched.
        step(1, 1, 32'h14);
        step(0, 0, 0);
        step(0, 0, 0);

        // End-of-memory guard: run through 1020, park, then recover via redirect.
        step(0, 1, 32'(IMEM_BYTES - 12));
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        step(1, 0, 0);
        step(0, 1, 32'h0);
        step(0, 0, 0);
        step(0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       tgt = $urandom();
                1:       tgt = 32'(IMEM_BYTES - 4);
                default: tgt = $urandom_range(0, IMEM_BYTES + 64);
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
        end

        // Asynchronous reset taken mid-cycle while pc=0x30.
        step(0, 1, 32'h30);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("async");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(0, 0, 0);
        step(0, 0, 0);

        // Misaligned redirect: masked by default, trapped when the feature is built in.
        step(0, 1, 32'h2A);
        step(0, 0, 0);
        step(0, 1, 32'h0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 32'h100);
        step(0, 0, 0);

        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        chk("scoreboard_pops", 32'(pops), 32'(pushes));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- PC-generation and IF/ID staging block; sits directly upstream of the byte-addressed, little-endian, combinational-read instruction memory.
- Drives `read_address` from the PC register and samples the returned `instruction_code` into the IF/ID pipeline register for the decoder.
- Handles sequential advance, branch/jump redirect with flush, stall, and end-of-memory guard.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 1024, instruction memory size in bytes; last legal fetch address is IMEM_BYTES-4.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- redirect_valid  input  1  taken branch/jal/jalr this cycle.
- redirect_target  input  32  byte address of redirect destination.
- read_address  output  32  fetch address to instruction memory, equal to pc.
- instruction_code  input  32  instruction word returned combinationally by instruction memory.
- if_id_pc  output  32  PC of staged instruction.
- if_id_pc_plus4  output  32  if_id_pc+4 (for jal/jalr link).
- if_id_instruction  output  32  staged instruction word.
- if_id_valid  output  1  staged instruction is valid.
- fetch_count  output  32  number of instructions captured valid since reset.
- fetch_fault  output  1  misaligned redirect seen (feature only; tied 0 otherwise).

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc=RESET_PC; if_id_pc=0, if_id_pc_plus4=0, if_id_instruction=32'h0000_0013 (nop), if_id_valid=0, fetch_count=0, fetch_fault=0; state=RUN.
- read_address = pc, combinational; no cycle of latency to memory.
- in_range = (pc <= IMEM_BYTES-4). All PC arithmetic is 32-bit, modulo 2^32.
- States: RUN, HALT (HALT is reachable only with the feature).
- RUN, per rising edge, in strict priority order:
  1. redirect_valid=1 (overrides stall):
     - pc <= aligned target {redirect_target[31:2],2'b00}.
     - if_id_valid <= 0 (flush); other IF/ID fields hold; fetch_count holds.
  2. stall=1: pc, IF/ID fields and fetch_count all hold.
  3. in_range=0: pc holds; if_id_valid <= 0. Fetch parks until a redirect arrives.
  4. Otherwise, advance:
     - pc <= pc+4.
     - if_id_pc <= pc; if_id_pc_plus4 <= pc+4; if_id_instruction <= instruction_code; if_id_valid <= 1.
     - fetch_count <= fetch_count+1, wrapping at 2^32.
- Latency: instruction at address A appears on the IF/ID outputs one edge after pc==A with no stall or redirect.
- After a redirect, the first valid instruction from the target appears one edge later: exactly one bubble.
- Stall held N cycles freezes all outputs for N cycles; advance resumes on the first edge with stall=0.
- pc reaching exactly IMEM_BYTES-4 is fetched normally; next pc=IMEM_BYTES, which is out of range and parks.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - redirect_valid with redirect_target[1:0]!=0 is not masked; instead fetch_fault <= 1, if_id_valid <= 0, pc holds, state <= HALT.
  - HALT ignores stall and redirect, keeps if_id_valid=0 and fetch_fault=1; only reset exits.
- Undefined: target low bits silently masked; fetch_fault tied 0; HALT state absent.

Test Plan:
- Reset, memory holding 0x003100B3 at 0 and 0x403100B3 at 4, no stall -> edge 1: if_id_pc=0, if_id_instruction=0x003100B3, if_id_valid=1; edge 2: if_id_pc=4, if_id_instruction=0x403100B3, if_id_pc_plus4=8; fetch_count=2.
- Stall asserted 3 cycles while pc=8 -> read_address=8 and all IF/ID outputs constant for 3 cycles; next edge captures address 8; fetch_count increments once.
- stall=1 and redirect_valid=1 with target=0x14 in the same cycle -> pc=0x14, if_id_valid=0 for one cycle; next edge if_id_pc=0x14, if_id_instruction=0x02A10093.
- Sequential run to pc=1020 (IMEM_BYTES=1024) -> 1020 captured valid; pc=1024, if_id_valid=0 thereafter; redirect to 0 -> resumes with if_id_pc=0.
- Redirect target=0x2A: without macro -> pc=0x28; with FETCH_MISALIGN_TRAP_EN -> fetch_fault=1, pc holds, if_id_valid stays 0 despite later redirects until reset.
- Async reset pulse mid-cycle while pc=0x30 -> outputs clear immediately without waiting for clk; pc=RESET_PC, fetch_count=0, if_id_instruction=0x00000013.
